// File: rtl/counter_pkg.sv
// Shared types, defaults and the round-robin search helper for the counter arbiter.
package counter_pkg;

    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_CNT_W   = 4;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned MAX_IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First set request at or after ptr, wrapping modulo num; returns ptr when none is set.
    function automatic logic [MAX_IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num
    );
        logic [MAX_IDX_W-1:0] idx;
        rr_next = ptr;
        for (int unsigned k = MAX_REQ; k > 0; k--) begin
            if (k <= num) begin
                idx = MAX_IDX_W'((32'(ptr) + k - 1) % num);
                if (req[idx]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Client-facing request/grant bus of the counter arbiter.
interface counter_arbiter_if #(
    parameter int unsigned NUM_REQ = counter_pkg::DEF_NUM_REQ,
    parameter int unsigned CNT_W   = counter_pkg::DEF_CNT_W
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] target;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [CNT_W-1:0]         counter;
    logic [NUM_REQ-1:0]       done;
    logic                     overflow;

    modport master (
        output req, target,
        input  grant, busy, counter, done, overflow
    );

    modport slave (
        input  req, target,
        output grant, busy, counter, done, overflow
    );
endinterface

// File: rtl/count_core.sv
// Shared up-counter datapath with synchronous clear and count enable.
module count_core
    import counter_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of the shared counter: grants one requester, counts to its target, pulses done.
module counter_arbiter
    import counter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    counter_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   w_winner, w_owner_inc;
    logic [CNT_W-1:0]   r_target, w_target_nxt;
    logic [CNT_W-1:0]   w_count, w_count_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_busy, r_overflow;
    logic               w_clear, w_enable;
    logic [CNT_W-1:0]   w_tgt [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_tgt_slice
        assign w_tgt[g] = bus.target[g*CNT_W +: CNT_W];
    end

    assign w_winner    = IDX_W'(rr_next(MAX_REQ'(bus.req), MAX_IDX_W'(r_ptr), NUM_REQ));
    assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    count_core #(
        .CNT_W (CNT_W)
    ) u_count_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_enable),
        .count  (w_count)
    );

    // Next-state and next-output decode; abort has priority over completion in RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_target_nxt = r_target;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_clear      = 1'b0;
        w_enable     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (|bus.req) begin
                    w_state_nxt  = ST_RUN;
                    w_owner_nxt  = w_winner;
                    w_target_nxt = w_tgt[w_winner];
                    w_grant_nxt  = NUM_REQ'(1) << w_winner;
                end
            end
            ST_RUN: begin
                if (!bus.req[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_clear     = 1'b1;
                    w_ptr_nxt   = w_owner_inc;
                end else if (w_count == r_target) begin
                    w_state_nxt = ST_DONE;
                    w_grant_nxt = '0;
                    w_done_nxt  = NUM_REQ'(1) << r_owner;
                end else begin
                    w_enable = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_clear     = 1'b1;
                w_ptr_nxt   = w_owner_inc;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_clear     = 1'b1;
            end
        endcase

        w_count_nxt = w_clear ? '0 : (w_enable ? w_count + CNT_W'(1) : w_count);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_target   <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_target   <= w_target_nxt;
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_overflow <= (w_state_nxt == ST_RUN) && (w_count_nxt == '1);
        end
    end

    assign bus.grant    = r_grant;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;
    assign bus.counter  = w_count;
endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one up-counter datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester asks for a timed interval by holding req[i] high with a terminal value on its target slice.
- The block grants one owner, counts from 0 up to that owner's target, then returns a one-cycle done pulse.
- Sits between the four-bit counter datapath and its clients; it is the counter's sequencer and owner.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CNT_W, 4, counter width in bits; target range 0..2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  level request per requester; held until done[i] or deliberately dropped.
- target  input  NUM_REQ*CNT_W  packed terminal counts; requester i uses target[i*CNT_W +: CNT_W].
- grant  output  NUM_REQ  one-hot current owner; all zero when no owner.
- busy  output  1  high in RUN and DONE.
- counter  output  CNT_W  live count value.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- overflow  output  1  one-cycle pulse when the counter reaches 2^CNT_W-1 in RUN.

Behaviour:
- Reset (reset low, asynchronous, effective mid-operation):
  - state = IDLE, ptr = 0.
  - grant, done, counter, busy and overflow are all 0.
  - A count in progress is discarded, with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - If any req bit is set, select the first set bit searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - On the next edge: latch the winner index and its target slice, set grant one-hot, set counter = 0, go to RUN.
  - Latency from req to grant is 1 edge.
- RUN, checked on each edge in this priority order:
  - Owner's req low: abort. Go to IDLE, grant = 0, counter = 0, no done pulse, ptr = owner+1 mod NUM_REQ.
  - counter == latched target: go to DONE, grant = 0.
  - Otherwise: counter increments by 1.
- Target is latched at grant. Changes to target after grant are ignored.
- Target 0 spends 1 cycle in RUN. Target T spends T+1 cycles in RUN.
- The counter never wraps, because target is at most 2^CNT_W-1.
- overflow is high during the RUN cycle in which counter == 2^CNT_W-1 (target all-ones only).
- DONE:
  - done[owner] is high for exactly this one cycle.
  - counter holds its final value.
  - On the next edge: ptr = owner+1 mod NUM_REQ, counter = 0, go to IDLE.
- Re-arbitration takes one IDLE cycle.
  - Back-to-back requests therefore see a 1-cycle gap between DONE and the next grant.
  - A requester that keeps req high after done is re-served only after others, per ptr.
- Requests arriving while busy stay pending; they are never lost and never pre-empt the owner.
- grant and done are never both high. At most one bit of each is set.
- The owner is the only requester that can abort. Other req edges during RUN have no effect.

Decomposition:
- Shared package (counter_pkg):
  - state encoding constants (ST_IDLE, ST_RUN, ST_DONE);
  - default CNT_W and NUM_REQ;
  - a rr_next function for round-robin index search.
- One sub-module: count_core.
  - Inputs: clk, reset, clear, enable.
  - Output: count, CNT_W bits.
  - Resets asynchronously to 0.
- The arbiter FSM drives count_core's clear and enable signals.

Test Plan:
- Single request, target 3: req[0]=1 with target slice 3 -> grant=001 one edge later; counter 0,1,2,3; done[0] pulses 1 cycle; busy for 5 cycles.
- Round-robin, all req high, targets 2/0/1: grant order 0,1,2,0; each done arrives on its owner; 1 idle cycle between grants.
- Target 0 and target 15: target 0 -> done after 1 RUN cycle. Target 15 -> overflow pulses exactly once, at counter=15, then done.
- Abort: req[1] dropped while counter=2 -> next edge grant=0, counter=0, no done; ptr moves to 2, so a pending req[2] wins next.
- Reset mid-RUN: reset low at counter=5 -> outputs zero immediately, without waiting for a clock edge. After release with req[2] high, ptr=0 search yields grant=100.
- Target changed after grant: target slice 4 -> 9 during RUN -> completes at 4.
